// File: rtl/enoc_pkg.sv
// Shared types and constants for the ENoC mesh router: port indices, flit layout
// and the one-hot output-port route vector.
package enoc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int C = 0;
    localparam int N = 1;
    localparam int E = 2;
    localparam int S = 3;
    localparam int W = 4;

    localparam int MESH_X_NODES   = 4;
    localparam int MESH_Y_NODES   = 4;
    localparam int FLIT_PAYLOAD_W = 32;

    // One spare code above the mesh size so an out-of-range destination can be carried.
    localparam int DEST_X_W = $clog2(MESH_X_NODES + 1);
    localparam int DEST_Y_W = $clog2(MESH_Y_NODES + 1);

    typedef logic [0:NUM_PORTS-1] route_t;

    typedef struct packed {
        logic [DEST_X_W-1:0]       dest_x;
        logic [DEST_Y_W-1:0]       dest_y;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage

// File: rtl/enoc_route_xy.sv
// Combinational dimension-ordered (X then Y) route for one flit destination.
// Out-of-range destinations are steered to the local core port and flagged.
module enoc_route_xy
    import enoc_pkg::*;
#(
    parameter int X_NODES = MESH_X_NODES,
    parameter int Y_NODES = MESH_Y_NODES,
    parameter int X_LOC   = 0,
    parameter int Y_LOC   = 0
) (
    input  logic [DEST_X_W-1:0] dest_x_i,
    input  logic [DEST_Y_W-1:0] dest_y_i,
    output route_t              route_o,
    output logic                range_err_o
);

    always_comb begin
        route_o     = '0;
        range_err_o = (int'(dest_x_i) >= X_NODES) || (int'(dest_y_i) >= Y_NODES);
        if (range_err_o) begin
            route_o[C] = 1'b1;
        end else if (int'(dest_x_i) > X_LOC) begin
            route_o[E] = 1'b1;
        end else if (int'(dest_x_i) < X_LOC) begin
            route_o[W] = 1'b1;
        end else if (int'(dest_y_i) > Y_LOC) begin
            route_o[S] = 1'b1;
        end else if (int'(dest_y_i) < Y_LOC) begin
            route_o[N] = 1'b1;
        end else begin
            route_o[C] = 1'b1;
        end
    end

endmodule

// File: rtl/enoc_input_unit.sv
// Per-input-port flit FIFO for an ENoC router: routes flits on enqueue and
// presents the head flit's one-hot output request to the switch controller.
module enoc_input_unit
    import enoc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int X_NODES   = 4,
    parameter int Y_NODES   = 4,
    parameter int X_LOC     = 0,
    parameter int Y_LOC     = 0,
    parameter int PAYLOAD_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ce,
    input  flit_t  i_data,
    input  logic   i_data_val,
    output logic   o_en,
    output route_t o_output_req,
    input  route_t i_output_grant,
    output flit_t  o_data,
    output logic   o_error
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FLIT_W = DEST_X_W + DEST_Y_W + PAYLOAD_W;

    logic [FLIT_W-1:0] flitMem_q [DEPTH];
    route_t            routeMem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic [FLIT_W-1:0] wrFlit;
    route_t            wrRoute;
    logic              wrRangeErr;
    logic              empty;
    logic              wrEn;
    logic              rdEn;
    logic              badGrant;

    enoc_route_xy #(
        .X_NODES (X_NODES),
        .Y_NODES (Y_NODES),
        .X_LOC   (X_LOC),
        .Y_LOC   (Y_LOC)
    ) u_route (
        .dest_x_i    (i_data.dest_x),
        .dest_y_i    (i_data.dest_y),
        .route_o     (wrRoute),
        .range_err_o (wrRangeErr)
    );

    assign wrFlit = i_data;
    assign empty  = (count_q == '0);

    // Backpressure comes only from registered occupancy, never from this cycle's grant.
    assign o_en         = (count_q < CNT_W'(DEPTH)) && !reset;
    assign o_output_req = empty ? '0 : routeMem_q[rdPtr_q];
    assign o_data       = empty ? '0 : flit_t'(flitMem_q[rdPtr_q]);

    always_comb begin
        wrEn     = ce && i_data_val && o_en;
        rdEn     = ce && ((i_output_grant & o_output_req) != '0);
        badGrant = ((i_output_grant & ~o_output_req) != '0) || ($countones(i_output_grant) > 1);

        wrPtr_d = wrPtr_q + PTR_W'(wrEn);
        rdPtr_d = rdPtr_q + PTR_W'(rdEn);
        count_d = count_q + CNT_W'(wrEn) - CNT_W'(rdEn);
        error_d = error_q
                | (ce && i_data_val && !o_en)
                | (wrEn && wrRangeErr)
                | (ce && badGrant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Storage is intentionally not reset; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            flitMem_q[wrPtr_q]  <= wrFlit;
            routeMem_q[wrPtr_q] <= wrRoute;
        end
    end

    assign o_error = error_q;

endmodule

// File: tb/tb_enoc_input_unit.sv
// Scoreboard bench for enoc_input_unit at router (1,1) of a 4x4 mesh.
module tb_enoc_input_unit;
    import enoc_pkg::*;

    localparam int DEPTH = 4;
    localparam int XN    = 4;
    localparam int YN    = 4;
    localparam int XL    = 1;
    localparam int YL    = 1;

    typedef struct packed {
        flit_t  flit;
        route_t route;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   ce;
    flit_t  i_data;
    logic   i_data_val;
    logic   o_en;
    route_t o_output_req;
    route_t i_output_grant;
    flit_t  o_data;
    logic   o_error;

    entry_t mq[$];
    bit     merr;
    int     vectors;
    int     miscompares;

    always #5 clk = ~clk;

    enoc_input_unit #(
        .DEPTH     (DEPTH),
        .X_NODES   (XN),
        .Y_NODES   (YN),
        .X_LOC     (XL),
        .Y_LOC     (YL),
        .PAYLOAD_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .i_data         (i_data),
        .i_data_val     (i_data_val),
        .o_en           (o_en),
        .o_output_req   (o_output_req),
        .i_output_grant (i_output_grant),
        .o_data         (o_data),
        .o_error        (o_error)
    );

    function automatic flit_t mkFlit(int x, int y, int p);
        flit_t f;
        f.dest_x  = DEST_X_W'(x);
        f.dest_y  = DEST_Y_W'(y);
        f.payload = FLIT_PAYLOAD_W'(p);
        return f;
    endfunction

    function automatic bit expRangeErr(flit_t f);
        return (int'(f.dest_x) >= XN) || (int'(f.dest_y) >= YN);
    endfunction

    function automatic route_t expRoute(flit_t f);
        int x = int'(f.dest_x);
        int y = int'(f.dest_y);
        if (expRangeErr(f)) return 5'b10000;
        if (x > XL)         return 5'b00100;
        if (x < XL)         return 5'b00001;
        if (y > YL)         return 5'b00010;
        if (y < YL)         return 5'b01000;
        return 5'b10000;
    endfunction

    task automatic setIn(input bit c, input bit v, input flit_t f, input route_t g);
        ce             = c;
        i_data_val     = v;
        i_data         = f;
        i_output_grant = g;
    endtask

    // Advance one clock, updating the scoreboard with what the bench drove.
    task automatic tick();
        route_t req;
        bit     en;
        entry_t e;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            merr = 1'b0;
        end else if (ce) begin
            en  = mq.size() < DEPTH;
            req = (mq.size() != 0) ? mq[0].route : route_t'(0);
            if (i_data_val && !en) merr = 1'b1;
            if ((i_output_grant & ~req) != 0) merr = 1'b1;
            if ($countones(i_output_grant) > 1) merr = 1'b1;
            if ((i_output_grant & req) != 0) void'(mq.pop_front());
            if (i_data_val && en) begin
                e.flit  = i_data;
                e.route = expRoute(i_data);
                mq.push_back(e);
                if (expRangeErr(i_data)) merr = 1'b1;
            end
        end
        #1;
    endtask

    task automatic resetCycle();
        reset = 1'b1;
        setIn(1'b1, 1'b0, '0, '0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setIn(1'b1, 1'b0, '0, '0);
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_en: got %b expected 0", o_en);
        end
        vectors++;
        if (o_output_req !== 5'b00000 || o_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: req %b data %h expected 0", o_output_req, o_data);
        end
        vectors++;
        if (o_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_error: got %b expected 0", o_error);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_en: got %b expected 1", o_en);
        end
        tick();
    endtask

    task automatic test_single();
        setIn(1'b1, 1'b1, mkFlit(3, 1, 32'hA5A5), '0);
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b1 || o_output_req !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL single_pre: en %b req %b expected en 1 req 00000", o_en, o_output_req);
        end
        tick();
        setIn(1'b1, 1'b0, '0, 5'b00100);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00100 || o_data !== mq[0].flit) begin
            miscompares++;
            $display("[TB] FAIL single_head: req %b data %h expected req 00100 data %h",
                     o_output_req, o_data, mq[0].flit);
        end
        tick();
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00000 || o_data !== '0 || o_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_drained: req %b data %h en %b expected 00000 0 1",
                     o_output_req, o_data, o_en);
        end
        tick();
    endtask

    task automatic test_fill();
        flit_t  fl   [4];
        route_t expR [4];
        fl[0] = mkFlit(3, 1, 11); expR[0] = 5'b00100;
        fl[1] = mkFlit(0, 2, 22); expR[1] = 5'b00001;
        fl[2] = mkFlit(1, 2, 33); expR[2] = 5'b00010;
        fl[3] = mkFlit(1, 0, 44); expR[3] = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            setIn(1'b1, 1'b1, fl[i], '0);
            @(negedge clk);
            vectors++;
            if (o_en !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fill_en_%0d: got %b expected 1", i, o_en);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            setIn(1'b1, 1'b0, '0, mq[0].route);
            @(negedge clk);
            vectors++;
            if (o_en !== ((i == 0) ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("[TB] FAIL fill_drain_en_%0d: got %b expected %b", i, o_en, (i != 0));
            end
            vectors++;
            if (o_output_req !== expR[i] || o_data !== mq[0].flit) begin
                miscompares++;
                $display("[TB] FAIL fill_order_%0d: req %b data %h expected req %b data %h",
                         i, o_output_req, o_data, expR[i], mq[0].flit);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        setIn(1'b1, 1'b1, mkFlit(3, 1, 100), '0);
        tick();
        for (int c = 0; c < 20; c++) begin
            setIn(1'b1, 1'b1, mkFlit(c % 4, (c / 4) % 4, 200 + c), mq[0].route);
            @(negedge clk);
            vectors++;
            if (o_en !== 1'b1 || o_output_req !== mq[0].route || o_data !== mq[0].flit) begin
                miscompares++;
                $display("[TB] FAIL b2b_%0d: en %b req %b data %h expected 1 %b %h",
                         c, o_en, o_output_req, o_data, mq[0].route, mq[0].flit);
            end
            tick();
        end
        setIn(1'b1, 1'b0, '0, mq[0].route);
        @(negedge clk);
        vectors++;
        if (o_data !== mq[0].flit) begin
            miscompares++;
            $display("[TB] FAIL b2b_last: data %h expected %h", o_data, mq[0].flit);
        end
        tick();
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL b2b_empty: req %b expected 00000", o_output_req);
        end
        tick();
    endtask

    task automatic test_routes();
        setIn(1'b1, 1'b1, mkFlit(1, 1, 55), '0);
        tick();
        setIn(1'b1, 1'b0, '0, 5'b10000);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b10000 || o_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL route_local: req %b err %b expected 10000 0", o_output_req, o_error);
        end
        tick();
        setIn(1'b1, 1'b1, mkFlit(4, 0, 66), '0);
        tick();
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b10000 || o_error !== merr) begin
            miscompares++;
            $display("[TB] FAIL route_range: req %b err %b expected 10000 %b", o_output_req, o_error, merr);
        end
        tick();
        setIn(1'b1, 1'b0, '0, 5'b10000);
        tick();
    endtask

    task automatic test_illegal();
        resetCycle();
        setIn(1'b1, 1'b1, mkFlit(3, 1, 77), '0);
        tick();
        setIn(1'b1, 1'b0, '0, 5'b01000);
        @(negedge clk);
        vectors++;
        if (o_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_pre_err: got %b expected 0", o_error);
        end
        tick();
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00100 || o_error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_wrong_grant: req %b err %b expected 00100 1", o_output_req, o_error);
        end
        for (int i = 0; i < 3; i++) begin
            setIn(1'b1, 1'b1, mkFlit(0, i, 80 + i), '0);
            tick();
        end
        setIn(1'b1, 1'b1, mkFlit(2, 2, 99), '0);
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_full_en: got %b expected 0", o_en);
        end
        tick();
        setIn(1'b1, 1'b0, '0, mq[0].route | 5'b01000);
        @(negedge clk);
        vectors++;
        if (o_data !== mq[0].flit) begin
            miscompares++;
            $display("[TB] FAIL illegal_multi_head: data %h expected %h", o_data, mq[0].flit);
        end
        tick();
        for (int i = 0; i < 8 && mq.size() != 0; i++) begin
            setIn(1'b1, 1'b0, '0, mq[0].route);
            @(negedge clk);
            vectors++;
            if (o_data !== mq[0].flit || o_error !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL illegal_drain_%0d: data %h err %b expected %h 1",
                         i, o_data, o_error, mq[0].flit);
            end
            tick();
        end
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00000 || o_error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_sticky: req %b err %b expected 00000 1", o_output_req, o_error);
        end
        tick();
    endtask

    task automatic test_ce_hold();
        resetCycle();
        for (int i = 0; i < 3; i++) begin
            setIn(1'b1, 1'b1, mkFlit(3 - i, 2, 300 + i), '0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            setIn(1'b0, 1'b1, mkFlit(0, 0, 400 + i), mq[0].route);
            @(negedge clk);
            vectors++;
            if (o_output_req !== mq[0].route || o_data !== mq[0].flit || o_en !== 1'b1 || o_error !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ce_hold_%0d: req %b data %h en %b err %b expected %b %h 1 0",
                         i, o_output_req, o_data, o_en, o_error, mq[0].route, mq[0].flit);
            end
            tick();
        end
        vectors++;
        if (mq.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL ce_hold_model: depth %0d expected 3", mq.size());
        end
        reset = 1'b1;
        setIn(1'b1, 1'b0, '0, '0);
        @(negedge clk);
        vectors++;
        if (o_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ce_reset_en: got %b expected 0", o_en);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_output_req !== 5'b00000 || o_data !== '0 || o_en !== 1'b1 || o_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ce_after_reset: req %b data %h en %b err %b expected 00000 0 1 0",
                     o_output_req, o_data, o_en, o_error);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        merr        = 1'b0;
        reset       = 1'b1;
        setIn(1'b1, 1'b0, '0, '0);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_routes();
        test_illegal();
        test_ce_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
